sysid_reader: RTL
=================

SYSID_READER -- requirements
Module: sysid_reader

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd0, value required at word 0 of the system-ID slave.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 32'd1392314294, value required at word 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535, maximum consecutive waitrequest cycles per read.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 Ports:
  clock            in   1   sole clock, rising edge
  reset            in   1   synchronous, active-high reset
  start            in   1   one-cycle request to run a check sequence
  avm_address      out  1   Avalon-MM master word address
  avm_read         out  1   Avalon-MM read request
  avm_waitrequest  in   1   slave stall; read accepted when low
  avm_readdata     in   32  slave read data, valid when read accepted
  id_value         out  32  captured word 0
  timestamp_value  out  32  captured word 1
  busy             out  1   sequence in progress
  done             out  1   one-cycle pulse at sequence end
  match            out  1   both words equal expected values
  timeout          out  1   sequence aborted on waitrequest timeout

Function
REQ-006 SHALL implement FSM states IDLE, RD_ID, RD_TS, FIN.
REQ-007 IDLE: start=1 -> RD_ID next edge; clear match, timeout, wait counter; id_value and timestamp_value hold.
REQ-008 RD_ID: avm_read=1, avm_address=0, both registered, stable until acceptance.
REQ-009 Acceptance = avm_read=1 and avm_waitrequest=0 in the same cycle; readdata captured on that edge.
REQ-010 RD_ID accepted -> capture id_value, RD_TS; no idle cycle between reads (back-to-back).
REQ-011 RD_TS: avm_read=1, avm_address=1; accepted -> capture timestamp_value, FIN.
REQ-012 FIN: avm_read=0, done=1 for exactly one cycle, match and timeout updated on entry, -> IDLE.
REQ-013 match=1 iff id_value==EXPECTED_ID and timestamp_value==EXPECTED_TIMESTAMP; held until next start.
REQ-014 busy=1 in RD_ID, RD_TS, FIN; 0 in IDLE.
REQ-015 start while busy=1 SHALL be ignored; start coincident with FIN ignored.
REQ-016 Latency with waitrequest always 0: start at cycle N -> read word 0 cycle N+1, word 1 cycle N+2, done cycle N+3.
REQ-017 Wait counter: 16-bit, increments each cycle avm_read=1 and avm_waitrequest=1, clears on acceptance and on state change; saturates, no wrap.

Reset
REQ-018 reset=1 SHALL force on next edge: state IDLE, avm_read=0, avm_address=0, busy=0, done=0, match=0, timeout=0, id_value=0, timestamp_value=0, counter=0.
REQ-019 reset mid-read SHALL drop avm_read next edge with no capture; start asserted with reset ignored.

Configuration
REQ-020 Macro SYSID_READER_TIMEOUT_EN SHALL compile in the timeout feature.
REQ-021 With SYSID_READER_TIMEOUT_EN defined: counter reaching TIMEOUT_CYCLES in RD_ID or RD_TS -> avm_read=0 next edge, timeout=1, match=0, FIN; uncaptured word keeps its previous value.
REQ-022 Without it: counter and TIMEOUT_CYCLES unused, reads wait indefinitely, timeout output tied 0.

Verification
REQ-023 Slave returns 0/1392314294, waitrequest=0, start at cycle 10 -> reads cycles 11,12, done cycle 13, match=1, timeout=0.
REQ-024 Slave returns word 1 = 1392314295 -> done, match=0, timestamp_value=1392314295.
REQ-025 waitrequest=1 for 5 cycles on each read -> address/read stable, done 13 cycles after start, match=1.
REQ-026 TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck 1 on word 1 -> read drops after 4 stall cycles, timeout=1, match=0, done pulse.
REQ-027 reset during RD_TS stall -> next cycle avm_read=0, all outputs 0; new start runs a clean sequence, match=1.
REQ-028 start pulsed during RD_ID and on FIN cycle -> exactly one done pulse, no second sequence.

Source files
------------

// File: rtl/sysid_reader.sv
// sysid_reader
// Reads word 0 (ID) and word 1 (build timestamp) from an Avalon-MM system-ID
// slave in two back-to-back reads. It then reports whether both words equal
// the expected values.
// Optional feature: define SYSID_READER_TIMEOUT_EN to abort a read that has
// stalled on waitrequest for TIMEOUT_CYCLES consecutive cycles.
module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1392314294,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state_q;
    logic        read_q;
    logic        address_q;
    logic        busy_q;
    logic        done_q;
    logic        match_q;
    logic [31:0] id_q;
    logic [31:0] ts_q;
    logic        accept;

    // A read completes on the edge where it is requested and not stalled.
    assign accept = read_q & ~avm_waitrequest;

`ifdef SYSID_READER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] wait_cnt_q;
    logic [15:0] wait_cnt_d;
    logic        stall;
    logic        timeout_hit;
    logic        timeout_q;

    assign stall = read_q & avm_waitrequest;

    // Saturating increment of the stall counter; it must never wrap to 0.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (wait_cnt_q != 16'hFFFF) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    // The read is abandoned on the edge that completes the TIMEOUT_CYCLES-th stall cycle.
    assign timeout_hit = stall && (wait_cnt_d >= TIMEOUT_LIMIT);

    // Count consecutive stall cycles; clear whenever the state changes.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (accept || timeout_hit || (state_q == IDLE)) begin
            wait_cnt_q <= '0;
        end else if (stall) begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Sequencer: issue both reads, capture the data and publish the verdict.
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            read_q    <= 1'b0;
            address_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            id_q      <= '0;
            ts_q      <= '0;
`ifdef SYSID_READER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            // NOTE: done defaults low each cycle, so setting it on entry to FIN makes a one-cycle pulse.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RD_ID;
                        read_q    <= 1'b1;
                        address_q <= 1'b0;
                        busy_q    <= 1'b1;
                        match_q   <= 1'b0;
`ifdef SYSID_READER_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                RD_ID: begin
                    if (accept) begin
                        id_q      <= avm_readdata;
                        address_q <= 1'b1;
                        state_q   <= RD_TS;
                    end
`ifdef SYSID_READER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        read_q    <= 1'b0;
                        address_q <= 1'b0;
                        timeout_q <= 1'b1;
                        match_q   <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= FIN;
                    end
`endif
                end
                RD_TS: begin
                    if (accept) begin
                        ts_q      <= avm_readdata;
                        read_q    <= 1'b0;
                        address_q <= 1'b0;
                        match_q   <= (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
                        done_q    <= 1'b1;
                        state_q   <= FIN;
                    end
`ifdef SYSID_READER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        read_q    <= 1'b0;
                        address_q <= 1'b0;
                        timeout_q <= 1'b1;
                        match_q   <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= FIN;
                    end
`endif
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign avm_read        = read_q;
    assign avm_address     = address_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign match           = match_q;
    assign id_value        = id_q;
    assign timestamp_value = ts_q;

endmodule
